// File: rtl/count4.sv
// count4 -- free-running binary up-counter with count enable and a
// registered terminal-count flag for chaining.
//
// Parameters:
//   WIDTH : counter width in bits (q is WIDTH bits wide)
//   MAX   : last value before wrap to 0; must be <= 2**WIDTH-1
//
// Ports:
//   clk   : system clock, rising-edge active
//   rst_n : asynchronous active-low reset; clears q and tc immediately
//   en    : count enable, active-high, sampled on the rising edge of clk
//   q     : current count value (registered)
//   tc    : terminal count (registered), high while q == MAX
module count4 #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned MAX   = (2 ** WIDTH) - 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] q,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  // Modulo-(MAX+1) increment: wraps to 0 after MAX, no carry-out.
  function automatic logic [WIDTH-1:0] wrap_inc(input logic [WIDTH-1:0] v);
    if (v == MAX_V) begin
      return '0;
    end
    return v + WIDTH'(1);
  endfunction

  logic [WIDTH-1:0] cnt_nxt;
  logic             tc_nxt;
  logic [WIDTH-1:0] cnt_p0;
  logic             tc_p0;

  // tc is derived from the next count so the flag and the count land in
  // the same register update and can never disagree.
  always_comb begin
    cnt_nxt = cnt_p0;
    if (en) begin
      cnt_nxt = wrap_inc(cnt_p0);
    end
    tc_nxt = (cnt_nxt == MAX_V);
  end

  // Stage p0: count and terminal-count registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p0 <= '0;
      tc_p0  <= 1'b0;
    end else begin
      cnt_p0 <= cnt_nxt;
      tc_p0  <= tc_nxt;
    end
  end

  assign q  = cnt_p0;
  assign tc = tc_p0;

endmodule

// File: tb/tb_count4.sv
module tb_count4;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] q;
  logic       tc;

  logic       rst3_n;
  logic       en3;
  logic [2:0] q3;
  logic       tc3;

  int n_checks = 0;
  int n_fail   = 0;

  count4 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .q     (q),
    .tc    (tc)
  );

  count4 #(.WIDTH(3), .MAX(5)) dut3 (
    .clk   (clk),
    .rst_n (rst3_n),
    .en    (en3),
    .q     (q3),
    .tc    (tc3)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance one rising edge, then sample on the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Pulse reset low between edges; called right after a falling edge.
  task automatic reset_pulse(input string tag);
    #2 rst_n = 1'b0;
    #1;
    check({tag, "_q"},  32'(q),  32'd0);
    check({tag, "_tc"}, 32'(tc), 32'd0);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    rst_n  = 1'b0;
    rst3_n = 1'b0;
    en     = 1'b1;
    en3    = 1'b1;

    // Power-up reset: outputs forced to 0 without any clock edge.
    #1;
    check("por_async_q",  32'(q),  32'd0);
    check("por_async_tc", 32'(tc), 32'd0);
    check("por_async_q3", 32'(q3), 32'd0);

    // Reset held for 100 ns with en high and clock running: no increments.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("por_hold_q",  32'(q),  32'd0);
      check("por_hold_tc", 32'(tc), 32'd0);
    end

    // Release at t=100 (falling edge); first increment at the edge at t=110.
    rst_n  = 1'b1;
    rst3_n = 1'b1;

    // Count and wrap: 20 edges from 0. WIDTH=3/MAX=5 instance checked alongside.
    for (int i = 1; i <= 20; i++) begin
      step();
      check("cnt_q",   32'(q),   32'(i % 16));
      check("cnt_tc",  32'(tc),  32'((i % 16) == 15));
      check("cnt3_q",  32'(q3),  32'(i % 6));
      check("cnt3_tc", 32'(tc3), 32'((i % 6) == 5));
    end

    // q is now 4; one more edge gives 5.
    step();
    check("pre_hold_q", 32'(q), 32'd5);

    // Enable hold for 3 cycles.
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_q",  32'(q),  32'd5);
      check("hold_tc", 32'(tc), 32'd0);
    end
    en = 1'b1;
    step();
    check("resume_q", 32'(q), 32'd6);

    // Advance to 9.
    for (int i = 7; i <= 9; i++) begin
      step();
      check("to9_q", 32'(q), 32'(i));
    end

    // Async reset mid-count between edges, then restart from 0.
    reset_pulse("rst_mid");
    for (int i = 1; i <= 3; i++) begin
      step();
      check("restart_q", 32'(q), 32'(i));
    end

    // Run up to MAX, then reset while tc is high.
    for (int i = 4; i <= 15; i++) begin
      step();
    end
    check("max_q",  32'(q),  32'd15);
    check("max_tc", 32'(tc), 32'd1);
    reset_pulse("rst_at_max");
    step();
    check("after_max_rst_q",  32'(q),  32'd1);
    check("after_max_rst_tc", 32'(tc), 32'd0);

    // Hold at MAX: tc must stay high while q stays at MAX.
    for (int i = 2; i <= 15; i++) begin
      step();
    end
    en = 1'b0;
    step();
    check("hold_max_q",  32'(q),  32'd15);
    check("hold_max_tc", 32'(tc), 32'd1);
    en = 1'b1;
    step();
    check("wrap2_q",  32'(q),  32'd0);
    check("wrap2_tc", 32'(tc), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
